// File: rtl/spad_pkg.sv
// Shared defaults for the scratchpad register file.
// Also holds the helper that sizes its address port.
package spad_pkg;

  localparam int SPAD_DATA_SIZE    = 8;
  localparam int SPAD_NUM_REGISTER = 16;

  // A depth of 2 or less still needs one address bit.
  function automatic int spad_addr_w(input int num_words);
    return (num_words > 2) ? $clog2(num_words) : 1;
  endfunction

endpackage

// File: rtl/spad.sv
// Flip-flop scratchpad: combinational read, synchronous write, asynchronous clear.
// Storage, write decode and read mux all live in this one flat module.
module spad
  import spad_pkg::*;
#(
  parameter int dataSize    = SPAD_DATA_SIZE,
  parameter int numRegister = SPAD_NUM_REGISTER
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic [dataSize-1:0]                   wr_data,
  input  logic [spad_addr_w(numRegister)-1:0]   addr,
  input  logic                                  wr_en,
  output logic [dataSize-1:0]                   rd_data
);

  localparam int ADDR_W = spad_addr_w(numRegister);

  if (numRegister < 2) begin : g_bad_depth_lo
    $error("spad: numRegister must be at least 2");
  end
  if (numRegister > 256) begin : g_bad_depth_hi
    $error("spad: numRegister must be at most 256");
  end
  if (dataSize < 1) begin : g_bad_width
    $error("spad: dataSize must be at least 1");
  end

  logic [dataSize-1:0] mem_q [numRegister];
  logic [dataSize-1:0] mem_d [numRegister];

  // Write decode: only an exact 1 on wr_en with a matching in-range address updates a word.
  always_comb begin
    for (int i = 0; i < numRegister; i++) begin
      if ((wr_en == 1'b1) && (addr == ADDR_W'(i))) begin
        mem_d[i] = wr_data;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Storage array, cleared the moment reset rises.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      for (int i = 0; i < numRegister; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read mux: addresses past the last word return zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < numRegister; i++) begin
      if (addr == ADDR_W'(i)) begin
        rd_data = mem_q[i];
      end else begin
        rd_data = rd_data;
      end
    end
  end

`ifndef SYNTHESIS
  a_wr_en_known: assert property (@(posedge clk) disable iff (nrst) !$isunknown(wr_en))
    else $error("spad: unknown value on wr_en");

  a_wr_addr_range: assert property (@(posedge clk) disable iff (nrst)
    (wr_en == 1'b1) |-> (int'(addr) < numRegister))
    else $warning("spad: write to address %0d beyond depth %0d dropped", addr, numRegister);
`endif

endmodule

// File: tb/tb_spad.sv
// Randomised bench for spad against an array model; checks a 16-deep and a 12-deep instance.
module tb_spad;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] wr_data;
  logic [3:0] addr;
  logic [3:0] addr12;
  logic       wr_en;
  logic [7:0] rd16;
  logic [7:0] rd12;

  logic [7:0] m16 [16];
  logic [7:0] m12 [12];
  int         vectors     = 0;
  int         miscompares = 0;
  bit         chk_en      = 1'b0;

  always #20 clk = ~clk;

  spad u_dut (
    .clk    (clk),
    .nrst   (nrst),
    .wr_data(wr_data),
    .addr   (addr),
    .wr_en  (wr_en),
    .rd_data(rd16)
  );

  spad #(.numRegister(12)) u_dut12 (
    .clk    (clk),
    .nrst   (nrst),
    .wr_data(wr_data),
    .addr   (addr12),
    .wr_en  (wr_en),
    .rd_data(rd12)
  );

  // Reference: an array that is written on an edge and wiped the instant reset rises.
  always @(posedge clk or posedge nrst) begin
    if (nrst) begin
      for (int i = 0; i < 16; i++) m16[i] <= 8'h00;
      for (int i = 0; i < 12; i++) m12[i] <= 8'h00;
    end else if (wr_en) begin
      m16[addr] <= wr_data;
      if (addr12 < 4'd12) m12[addr12] <= wr_data;
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd16_model", rd16, m16[addr]);
      check("rd12_model", rd12, (addr12 < 4'd12) ? m12[addr12] : 8'h00);
    end
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    addr    = a;
    addr12  = a;
    wr_data = d;
    wr_en   = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  initial begin
    nrst    = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    addr    = 4'd0;
    addr12  = 4'd0;
    #2;
    nrst    = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    chk_en  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      addr   = 4'(i);
      addr12 = 4'(i);
      #1;
      check("reset_sweep16", rd16, 8'h00);
      check("reset_sweep12", rd12, 8'h00);
    end
    repeat (2) @(posedge clk);
    #1;
    nrst  = 1'b0;
    wr_en = 1'b0;

    // Fill on consecutive edges, the first one right after reset release.
    for (int i = 0; i < 16; i++) wr(4'(i), 8'(i * 3 + 1));
    idle();
    for (int i = 0; i < 16; i++) begin
      addr   = 4'(i);
      addr12 = 4'(i);
      #1;
      check("fill_read", rd16, 8'(i * 3 + 1));
    end

    wr(4'd5, 8'h11);
    wr(4'd5, 8'hA5);
    #2;
    check("rdw_before", rd16, 8'h11);
    @(posedge clk);
    #1;
    check("rdw_after", rd16, 8'hA5);
    wr_en = 1'b0;

    wr_data = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      addr   = 4'($urandom_range(15, 0));
      addr12 = addr;
    end
    addr = 4'd7;
    #1;
    check("hold_addr7", rd16, 8'h16);

    wr(4'd3, 8'h80);
    idle();
    addr   = 4'd3;
    addr12 = 4'd3;
    #1;
    check("neg_value16", rd16, 8'h80);
    check("neg_value12", rd12, 8'h80);

    wr(4'd13, 8'hC3);
    idle();
    #1;
    check("oor_read12", rd12, 8'h00);
    check("wr13_16", rd16, 8'hC3);
    addr12 = 4'd1;
    #1;
    check("oor_no_alias12", rd12, 8'h04);

    // Reset pulsed between edges partway through a fresh fill.
    for (int i = 0; i < 8; i++) wr(4'(i), 8'(i * 5 + 2));
    idle();
    addr = 4'd4;
    #1;
    check("midfill_pre", rd16, 8'h16);
    nrst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      addr   = 4'(i);
      addr12 = 4'(i);
      #1;
      check("midfill_rst16", rd16, 8'h00);
      check("midfill_rst12", rd12, 8'h00);
    end
    nrst = 1'b0;
    wr(4'd2, 8'h3C);
    wr(4'd9, 8'h99);
    idle();
    addr = 4'd2;
    #1;
    check("resume_a2", rd16, 8'h3C);
    addr = 4'd9;
    #1;
    check("resume_a9", rd16, 8'h99);
    addr = 4'd0;
    #1;
    check("resume_a0_cleared", rd16, 8'h00);

    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      addr    = 4'($urandom_range(15, 0));
      addr12  = 4'($urandom_range(15, 0));
      wr_data = 8'($urandom);
      wr_en   = ($urandom_range(3, 0) != 0);
      if ($urandom_range(59, 0) == 0) begin
        nrst = 1'b1;
        #3;
        nrst = 1'b0;
      end
    end
    idle();
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
